// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction memory.
// Assembles little-endian 32-bit words from a valid/ready byte stream and
// issues one single-cycle word write per word, starting at base_addr.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a running 32-bit sum
// of all written words on output port checksum.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both high; in_ready depends only on state, never on in_valid.
module imem_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [IDX_W:0]   len_words,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);
    localparam logic [IDX_W:0]   ONE_WORD = (IDX_W + 1)'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [IDX_W:0]    remaining_q, remaining_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum_q, checksum_d;
`endif

    // Upper base address bits lie outside the memory and are intentionally ignored.
    logic unused_base_bits;
    assign unused_base_bits = ^base_addr[31:IDX_W+2];

    // State and datapath registers; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            error_q     <= error_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running word sum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (base_addr[1:0] != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (len_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d  = base_addr[IDX_W+1:2];
                        remaining_d = len_words;
                        byte_idx_d  = 2'd0;
                        state_d     = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (in_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = in_byte;
                        2'd1: word_d[15:8]  = in_byte;
                        2'd2: word_d[23:16] = in_byte;
                        default: begin
                            // Last byte: present address and word in the WRITE cycle
                            // and hold them afterwards.
                            mem_wdata_d = {in_byte, word_q};
                            mem_addr_d  = {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
                            state_d     = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                remaining_d = remaining_q - ONE_WORD;
                word_idx_d  = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
                byte_idx_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                checksum_d  = checksum_q + mem_wdata_q;
`endif
                state_d     = (remaining_q == ONE_WORD) ? S_DONE : S_RECV;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_RECV);
    assign mem_we    = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Expected writes ({addr, data}) are queued by the stimulus; a monitor pops
// and compares on every mem_we. Build with IMEM_LOADER_CHECKSUM_EN to also
// check the checksum output.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] len_words;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  dbg_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    imem_loader #(.MEM_DEPTH(1024), .IDX_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len_words (len_words),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h with no write expected",
                         mem_addr, mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             mem_addr, mem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_start(input logic [31:0] base, input logic [10:0] len);
        start     = 1'b1;
        base_addr = base;
        len_words = len;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
        bit acc;
        int n;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (chk_ready) check("ready_in_gap", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("byte_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Sends a word LSB first; gap>0 inserts that many idle cycles before each byte.
    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[8*k +: 8], gap, k != 0);
        end
    endtask

    // Called right after the last byte handshake of a load.
    task automatic finish_load(input string name, input logic [31:0] exp_sum);
        @(negedge clk);
        check({name, "_last_we"}, mem_we, 1);
        check({name, "_no_early_done"}, done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_done"}, done, 1);
        check({name, "_busy_in_done"}, busy, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({name, "_checksum"}, checksum, exp_sum);
`else
        if (exp_sum == 32'hFFFF_FFFF) $display("note: unexpected checksum sentinel");
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 0);
        check({name, "_idle"}, busy, 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; len_words = '0;
        in_byte = '0; in_valid = 1'b0;

        // Test 1: reset for 2 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 2: two words, in_valid held high.
        do_start(32'h0, 11'd2);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        finish_load("t2", 32'h0010_00A6);

        // Test 3: same data with idle cycles between bytes.
        do_start(32'h0, 11'd2);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_word(32'h0000_0013, 2);
        send_word(32'h0010_0093, 3);
        finish_load("t3", 32'h0010_00A6);

        // Test 4: index wrap at top of memory; start during load ignored.
        do_start(32'h0000_0FFC, 11'd2);
        exp_q.push_back({32'h0000_0FFC, 32'h1122_3344});
        exp_q.push_back({32'h0000_0000, 32'hAABB_CCDD});
        send_byte(8'h44, 0, 0);
        start = 1'b1; base_addr = 32'h0000_0040; len_words = 11'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h33, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h11, 0, 0);
        send_word(32'hAABB_CCDD, 0);
        finish_load("t4", 32'hBBDE_0021);

        // Test 5a: zero-length load.
        do_start(32'h0, 11'd0);
        @(negedge clk);
        check("t5_len0_done", done, 1);
        check("t5_len0_err", error, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_len0_idle", busy, 0);
        @(posedge clk); #1;
        // Test 5b: misaligned base.
        do_start(32'h0000_0002, 11'd1);
        @(negedge clk);
        check("t5_mis_err", error, 1);
        check("t5_mis_done", done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_mis_err_sticky", error, 1);
        check("t5_mis_done_pulse", done, 0);
        @(posedge clk); #1;
        // Test 5c: next valid start clears error.
        do_start(32'h0, 11'd0);
        @(negedge clk);
        check("t5_err_cleared", error, 0);
        @(posedge clk); #1;
        check("t5_queue_drained", exp_q.size(), 0);

        // Test 6: reset mid-word discards the partial word.
        do_start(32'h0000_0100, 11'd1);
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_we", mem_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t6_no_partial_write", exp_q.size(), 0);
        do_start(32'h0000_0100, 11'd1);
        exp_q.push_back({32'h0000_0100, 32'hEFBE_ADDE});
        send_word(32'hEFBE_ADDE, 0);
        finish_load("t6", 32'hEFBE_ADDE);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
